// File: rtl/imem_load_pkg.sv
// Shared types for the instruction-memory load responder.
// Optional feature macro: LOAD_CHECKSUM_EN (see imem_load_responder.sv).
package imem_load_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } load_state_e;

  // One instruction-memory write beat at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } imem_beat_t;

endpackage

// File: rtl/load_fifo.sv
// Small synchronous FIFO that buffers instruction-memory write beats.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module load_fifo
  import imem_load_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type beat_t = imem_beat_t
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  beat_t push_beat,
  input  logic  pop,
  output beat_t head_beat,
  output logic  full,
  output logic  empty
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  beat_t       mem_q [DEPTH];

  // Advance each pointer by one on its own handshake.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; reset empties the FIFO and discards buffered beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Beat storage, written at the tail.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= push_beat;
  end

  assign head_beat = mem_q[rd_ptr_q[PW-1:0]];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/imem_load_responder.sv
// Memory-init and register-file debug responder.
// Buffers instruction-memory write beats, commits them in order, keeps the
// core stalled until loading completes, and returns registered RF reads.
// Optional feature macro: LOAD_CHECKSUM_EN adds output load_csum, the
// modulo-2^DATA_W sum of committed write data in the current load window.
module imem_load_responder
  import imem_load_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int IMEM_WORDS = 4096,
  parameter int FIFO_DEPTH = 4,
  parameter int RF_ADDR_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_mem,
  input  logic                 imem_write,
  input  logic [ADDR_W-1:0]    imem_addr,
  input  logic [DATA_W-1:0]    imem_wdata,
  output logic                 load_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_busy,
  output logic                 cpu_stall,
  output logic                 load_done,
  output logic [ADDR_W:0]      load_count,
  output logic                 err_flag,
  input  logic [RF_ADDR_W-1:0] rf_raddr1,
  input  logic [RF_ADDR_W-1:0] rf_raddr2,
  output logic [RF_ADDR_W-1:0] rf_core_raddr1,
  output logic [RF_ADDR_W-1:0] rf_core_raddr2,
  input  logic [DATA_W-1:0]    rf_core_rdata1,
  input  logic [DATA_W-1:0]    rf_core_rdata2,
  output logic [DATA_W-1:0]    rf_rdata1,
  output logic [DATA_W-1:0]    rf_rdata2
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]    load_csum
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Addresses are compared one bit wider so IMEM_WORDS = 2^ADDR_W still fits.
  localparam logic [ADDR_W:0] IMEM_LIMIT = (ADDR_W+1)'(IMEM_WORDS);
  localparam logic [ADDR_W:0] COUNT_ONE  = 1;
  localparam logic [ADDR_W:0] COUNT_MAX  = COUNT_ONE << ADDR_W;

  load_state_e       state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd1_q, rd2_q;

  beat_t push_beat, head_beat;
  logic  fifo_full, fifo_empty;
  logic  in_range, push, pop, window_open;

  assign push_beat = '{addr: imem_addr, data: imem_wdata};
  assign in_range  = ({1'b0, imem_addr} < IMEM_LIMIT);
  assign push      = imem_write & load_ready & in_range;
  assign pop       = mem_we & ~mem_busy;

  load_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .beat_t (beat_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .head_beat (head_beat),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a load window stays open while init_mem is high, then drains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = init_mem ? LOAD : RUN;
      LOAD:    if (!init_mem) state_d = fifo_empty ? RUN : DRAIN;
      DRAIN:   if (fifo_empty) state_d = RUN;
               else if (init_mem) state_d = LOAD;
      RUN:     if (init_mem) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the core runs only in RUN; beats are taken and committed in the load states.
  always_comb begin
    cpu_stall  = (state_q != RUN);
    load_ready = (state_q == LOAD) & ~fifo_full;
    mem_we     = ~fifo_empty & ((state_q == LOAD) | (state_q == DRAIN));
  end

  // A fresh window starts when LOAD is entered from IDLE or RUN (not when DRAIN is reopened).
  assign window_open = (state_d == LOAD) && ((state_q == IDLE) || (state_q == RUN));

  // Commit counter, sticky error and load-done pulse.
  always_comb begin
    count_d = count_q;
    if (window_open)                    count_d = '0;
    else if (pop && count_q != COUNT_MAX) count_d = count_q + COUNT_ONE;

    err_d  = err_q
           | (imem_write & (state_q != LOAD))
           | (imem_write & load_ready & ~in_range);
    done_d = (state_d == RUN) && (state_q != RUN);
  end

  // Status and debug-read registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rd1_q   <= rf_core_rdata1;
      rd2_q   <= rf_core_rdata2;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Running sum of committed data, restarted with each fresh window.
  always_comb begin
    csum_d = csum_q;
    if (window_open) csum_d = '0;
    else if (pop)    csum_d = csum_q + head_beat.data;
  end

  // Checksum register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign load_csum = csum_q;
`endif

  assign mem_addr       = head_beat.addr;
  assign mem_wdata      = head_beat.data;
  assign load_done      = done_q;
  assign load_count     = count_q;
  assign err_flag       = err_q;
  assign rf_core_raddr1 = rf_raddr1;
  assign rf_core_raddr2 = rf_raddr2;
  assign rf_rdata1      = rd1_q;
  assign rf_rdata2      = rd2_q;

endmodule

// File: tb/tb_imem_load_responder.sv
// Bench for imem_load_responder: directed scenarios plus a randomized phase,
// all checked every cycle against a queue-based model of the load protocol.
module tb_imem_load_responder;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int IMEM_WORDS = 1024;
  localparam int DEPTH      = 4;
  localparam int RF_ADDR_W  = 5;
  localparam int SAT        = 1 << ADDR_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 init_mem, imem_write, mem_busy;
  logic [ADDR_W-1:0]    imem_addr;
  logic [DATA_W-1:0]    imem_wdata;
  logic                 load_ready, mem_we, cpu_stall, load_done, err_flag;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [ADDR_W:0]      load_count;
  logic [RF_ADDR_W-1:0] rf_raddr1, rf_raddr2, rf_core_raddr1, rf_core_raddr2;
  logic [DATA_W-1:0]    rf_core_rdata1, rf_core_rdata2, rf_rdata1, rf_rdata2;
`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0]    load_csum;
`endif

  logic [DATA_W-1:0] rf [32];
  assign rf_core_rdata1 = rf[rf_core_raddr1];
  assign rf_core_rdata2 = rf[rf_core_raddr2];

  imem_load_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMEM_WORDS(IMEM_WORDS),
    .FIFO_DEPTH(DEPTH), .RF_ADDR_W(RF_ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .init_mem(init_mem), .imem_write(imem_write),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .load_ready(load_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .cpu_stall(cpu_stall), .load_done(load_done),
    .load_count(load_count), .err_flag(err_flag),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_core_raddr1(rf_core_raddr1), .rf_core_raddr2(rf_core_raddr2),
    .rf_core_rdata1(rf_core_rdata1), .rf_core_rdata2(rf_core_rdata2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
`ifdef LOAD_CHECKSUM_EN
    , .load_csum(load_csum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases of the load protocol, as plain integers.
  localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_RUN = 3;
  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } beat_s;

  int                m_mode;
  beat_s             m_q[$];
  int                m_count;
  bit                m_err, m_done;
  logic [DATA_W-1:0] m_rd1, m_rd2, m_csum;

  logic [DATA_W-1:0] mem_img [IMEM_WORDS];
  int                commits = 0;
  int                done_pulses = 0;
  bit                e_ready, e_we;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_q.delete();
    m_count = 0;
    m_err   = 1'b0;
    m_done  = 1'b0;
    m_rd1   = '0;
    m_rd2   = '0;
    m_csum  = '0;
  endtask

  // One clock of protocol behaviour, using the inputs held for the coming edge.
  task automatic model_step();
    bit    ready, we, inr, pop, push;
    int    nxt;
    beat_s b;
    ready = (m_mode == M_LOAD) && (m_q.size() < DEPTH);
    we    = (m_q.size() > 0) && (m_mode == M_LOAD || m_mode == M_DRAIN);
    inr   = (int'(imem_addr) < IMEM_WORDS);
    pop   = we && !mem_busy;
    push  = imem_write && ready && inr;
    if (imem_write && (m_mode != M_LOAD || (ready && !inr))) m_err = 1'b1;
    nxt = m_mode;
    case (m_mode)
      M_IDLE:  nxt = init_mem ? M_LOAD : M_RUN;
      M_LOAD:  if (!init_mem) nxt = (m_q.size() == 0) ? M_RUN : M_DRAIN;
      M_DRAIN: if (m_q.size() == 0) nxt = M_RUN; else if (init_mem) nxt = M_LOAD;
      default: if (init_mem) nxt = M_LOAD;
    endcase
    if (pop) begin
      b = m_q.pop_front();
      if (m_count < SAT) m_count++;
      m_csum = m_csum + b.d;
    end
    if (push) begin
      b.a = imem_addr;
      b.d = imem_wdata;
      m_q.push_back(b);
    end
    if (nxt == M_LOAD && (m_mode == M_IDLE || m_mode == M_RUN)) begin
      m_count = 0;
      m_csum  = '0;
    end
    m_done = (nxt == M_RUN) && (m_mode != M_RUN);
    m_rd1  = rf[rf_raddr1];
    m_rd2  = rf[rf_raddr2];
    m_mode = nxt;
  endtask

  // Compare process: outputs are sampled on the falling edge, then the model advances.
  always @(negedge clk) begin
    if (!reset) model_reset();
    e_ready = (m_mode == M_LOAD) && (m_q.size() < DEPTH);
    e_we    = (m_q.size() > 0) && (m_mode == M_LOAD || m_mode == M_DRAIN);
    check("cmp_load_ready", load_ready, e_ready);
    check("cmp_mem_we",     mem_we,     e_we);
    check("cmp_cpu_stall",  cpu_stall,  m_mode != M_RUN);
    check("cmp_load_done",  load_done,  m_done);
    check("cmp_load_count", load_count, m_count);
    check("cmp_err_flag",   err_flag,   m_err);
    check("cmp_rf_rdata1",  rf_rdata1,  m_rd1);
    check("cmp_rf_rdata2",  rf_rdata2,  m_rd2);
    check("cmp_rf_craddr1", rf_core_raddr1, rf_raddr1);
    check("cmp_rf_craddr2", rf_core_raddr2, rf_raddr2);
`ifdef LOAD_CHECKSUM_EN
    check("cmp_load_csum",  load_csum,  m_csum);
`endif
    if (e_we) begin
      check("cmp_mem_addr",  mem_addr,  m_q[0].a);
      check("cmp_mem_wdata", mem_wdata, m_q[0].d);
    end
    if (mem_we && !mem_busy) begin
      commits++;
      if (int'(mem_addr) < IMEM_WORDS) mem_img[mem_addr] = mem_wdata;
    end
    if (load_done) done_pulses++;
    if (reset) model_step();
  end

  // ---------------- stimulus helpers ----------------
  int accepted = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the responder takes it.
  task automatic write_beat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit got = 1'b0;
    imem_write = 1'b1;
    imem_addr  = a;
    imem_wdata = d;
    for (int i = 0; i < 200 && !got; i++) begin
      got = load_ready;
      tick();
    end
    if (got) accepted++;
    check("beat_accepted", got, 1'b1);
  endtask

  task automatic wait_run(input int limit);
    for (int i = 0; i < limit && cpu_stall; i++) tick();
    check("reach_run", cpu_stall, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [DATA_W-1:0] t3_data [6];
  int                c0;

  initial begin
    reset = 1'b0; init_mem = 1'b0; imem_write = 1'b0; mem_busy = 1'b0;
    imem_addr = '0; imem_wdata = '0; rf_raddr1 = '0; rf_raddr2 = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < IMEM_WORDS; i++) mem_img[i] = '0;
    tick(); tick();

    // Reset values.
    check("rst_cpu_stall",  cpu_stall,  1'b1);
    check("rst_load_ready", load_ready, 1'b0);
    check("rst_mem_we",     mem_we,     1'b0);
    check("rst_load_done",  load_done,  1'b0);
    check("rst_load_count", load_count, 0);
    check("rst_err_flag",   err_flag,   1'b0);
    check("rst_rf_rdata1",  rf_rdata1,  0);

    // 1: straight to RUN.
    reset = 1'b1;
    tick();
    check("t1_cpu_stall",  cpu_stall,  1'b0);
    check("t1_load_done",  load_done,  1'b1);
    check("t1_load_count", load_count, 0);
    tick();
    check("t1_done_low",   load_done,  1'b0);

    // 2: eight beats, no backpressure.
    init_mem = 1'b1;
    tick();
    c0 = commits;
    for (int i = 0; i < 8; i++) write_beat(ADDR_W'(i), DATA_W'(32'h13 + i));
    imem_write = 1'b0;
    done_pulses = 0;
    init_mem = 1'b0;
    wait_run(50);
    tick(); tick();
    for (int i = 0; i < 8; i++) check("t2_mem_word", mem_img[i], 32'h13 + i);
    check("t2_load_count", load_count, 8);
    check("t2_commits",    commits - c0, 8);
    check("t2_done_once",  done_pulses, 1);
`ifdef LOAD_CHECKSUM_EN
    // 0x13 + 0x14 + ... + 0x1A
    check("t2_load_csum",  load_csum, 32'hB4);
`endif

    // 3: memory busy for 10 cycles while six beats are offered.
    init_mem = 1'b1;
    mem_busy = 1'b1;
    tick();
    c0 = commits;
    accepted = 0;
    for (int i = 0; i < 6; i++) t3_data[i] = $urandom;
    fork
      begin
        for (int i = 0; i < 6; i++) write_beat(ADDR_W'(100 + i), t3_data[i]);
        imem_write = 1'b0;
      end
      begin
        repeat (10) tick();
        check("t3_ready_full", load_ready, 1'b0);
        check("t3_accepted_4", accepted, 4);
        mem_busy = 1'b0;
      end
    join
    init_mem = 1'b0;
    wait_run(50);
    tick();
    for (int i = 0; i < 6; i++) check("t3_mem_word", mem_img[100 + i], t3_data[i]);
    check("t3_load_count", load_count, 6);
    check("t3_commits",    commits - c0, 6);

    // 4: a beat while running, then an out-of-range beat in a window.
    check("t4_err_before", err_flag, 1'b0);
    c0 = commits;
    imem_write = 1'b1; imem_addr = 12'd3; imem_wdata = 32'h0BAD;
    tick();
    imem_write = 1'b0;
    tick();
    check("t4_err_run",    err_flag, 1'b1);
    check("t4_count_keep", load_count, 6);
    check("t4_mem3_keep",  mem_img[3], 32'h16);
    init_mem = 1'b1;
    tick();
    write_beat(12'hFFF, 32'h5555);
    imem_write = 1'b0;
    init_mem = 1'b0;
    wait_run(50);
    tick();
    check("t4_count_zero", load_count, 0);
    check("t4_no_commit",  commits - c0, 0);
    check("t4_err_sticky", err_flag, 1'b1);

    // 5: reset with three beats buffered.
    init_mem = 1'b1;
    mem_busy = 1'b1;
    tick();
    c0 = commits;
    for (int i = 0; i < 3; i++) write_beat(ADDR_W'(200 + i), $urandom);
    imem_write = 1'b0;
    check("t5_we_before", mem_we, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("t5_we_async",  mem_we, 1'b0);
    tick();
    reset = 1'b1;
    mem_busy = 1'b0;
    check("t5_count_rst", load_count, 0);
    check("t5_err_rst",   err_flag, 1'b0);
    tick();
    check("t5_empty",     mem_we, 1'b0);
    check("t5_ready",     load_ready, 1'b1);
    init_mem = 1'b0;
    wait_run(50);
    check("t5_no_commit", commits - c0, 0);

    // 6: registered register-file debug reads.
    rf[5]  = 32'hDEADBEEF;
    rf[31] = 32'h12345678;
    rf_raddr1 = 5'd5;
    rf_raddr2 = 5'd31;
    #1;
    check("t6_core_raddr1", rf_core_raddr1, 5);
    tick();
    check("t6_rf_rdata1", rf_rdata1, 32'hDEADBEEF);
    check("t6_rf_rdata2", rf_rdata2, 32'h12345678);

    // Saturation: more than 2^ADDR_W commits in one window.
    init_mem = 1'b1;
    tick();
    for (int i = 0; i < SAT + 4; i++) write_beat(ADDR_W'(i % IMEM_WORDS), DATA_W'(i));
    imem_write = 1'b0;
    init_mem = 1'b0;
    wait_run(50);
    tick();
    check("sat_load_count", load_count, SAT);

    // Randomized phase; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) init_mem = ~init_mem;
      imem_write = ($urandom_range(0, 1) == 1);
      imem_addr  = ADDR_W'($urandom_range(0, IMEM_WORDS + 80));
      imem_wdata = $urandom;
      mem_busy   = ($urandom_range(0, 9) < 3);
      rf_raddr1  = RF_ADDR_W'($urandom);
      rf_raddr2  = RF_ADDR_W'($urandom);
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1; imem_write = 1'b0; init_mem = 1'b0; mem_busy = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
